digital_clock: RTL and testbench

//  24-hour HH:MM wall clock with BCD digit outputs for the 4-digit display driver.

---
 rtl/clock_pkg.sv | 58 +++++
 rtl/btn_sync_edge.sv | 57 +++++
 rtl/digital_clock.sv | 87 ++++++++
 tb/tb_digital_clock.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and BCD advance helpers for the HH:MM wall clock.
// Each helper wraps any out-of-range digit to 0 and carries, so forced invalid states self-heal.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MAX_TENMIN     = 4'd5;
    localparam bcd_t MAX_TENHR      = 4'd2;
    localparam bcd_t MAX_ONEHR_AT_2 = 4'd3;
    localparam bcd_t MAX_DIGIT      = 4'd9;

    typedef struct packed {
        bcd_t tenhr;
        bcd_t onehr;
        bcd_t tenmin;
        bcd_t onemin;
    } hhmm_t;

    function automatic hhmm_t adv_hour(input hhmm_t t);
        hhmm_t r;
        r = t;
        if (t.tenhr >= MAX_TENHR && t.onehr >= MAX_ONEHR_AT_2) begin
            r.tenhr = '0;
            r.onehr = '0;
        end else if (t.onehr >= MAX_DIGIT) begin
            r.onehr = '0;
            r.tenhr = t.tenhr + 4'd1;
        end else begin
            r.onehr = t.onehr + 4'd1;
        end
        return r;
    endfunction

    function automatic hhmm_t adv_tenmin(input hhmm_t t);
        hhmm_t r;
        if (t.tenmin >= MAX_TENMIN) begin
            r        = adv_hour(t);
            r.tenmin = '0;
        end else begin
            r        = t;
            r.tenmin = t.tenmin + 4'd1;
        end
        return r;
    endfunction

    function automatic hhmm_t adv_min(input hhmm_t t);
        hhmm_t r;
        if (t.onemin >= MAX_DIGIT) begin
            r        = adv_tenmin(t);
            r.onemin = '0;
        end else begin
            r        = t;
            r.onemin = t.onemin + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer, optional stability filter, and rising-edge pulse for one async input.
// The filter accepts a new level only after it has differed from the accepted level for DEBOUNCE_CYCLES cycles.
module btn_sync_edge #(
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic sync_p0;
    logic sync_p1;
    logic stable_p1;
    logic prev_p2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            prev_p2 <= stable_p1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            assign stable_p1 = sync_p1;
        end else begin : g_deb
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [CW-1:0] deb_cnt;
            logic          deb_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    deb_cnt <= '0;
                    deb_q   <= 1'b0;
                end else if (sync_p1 == deb_q) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_cnt <= '0;
                    deb_q   <= sync_p1;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end

            assign stable_p1 = deb_q;
        end
    endgenerate

    assign pulse = stable_p1 & ~prev_p2;

endmodule

// File: rtl/digital_clock.sv
// 24-hour HH:MM clock driven by a sampled 1 Hz strobe, with +1 min and +10 min set buttons.
// One advance per cycle: tenminbtn beats minbtn beats the tick; a displaced tick advance waits in pending.
module digital_clock
    import clock_pkg::*;
#(
    parameter int SEC_PER_MIN     = 60,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic       clk100MHz,
    input  logic       rst,
    input  logic       clk1sec,
    input  logic       minbtn,
    input  logic       tenminbtn,
    output logic [3:0] tenhrout,
    output logic [3:0] onehrout,
    output logic [3:0] tenminout,
    output logic [3:0] oneminout
);

    logic       tick_p;
    logic       min_p;
    logic       tenmin_p;
    logic [5:0] sec_cnt;
    logic       sec_wrap;
    logic       pending;
    logic       pending_nxt;
    hhmm_t      now_q;
    hhmm_t      now_nxt;

    btn_sync_edge #(.DEBOUNCE_CYCLES(0)) u_sync_sec (
        .clk   (clk100MHz),
        .rst   (rst),
        .din   (clk1sec),
        .pulse (tick_p)
    );

    btn_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_min (
        .clk   (clk100MHz),
        .rst   (rst),
        .din   (minbtn),
        .pulse (min_p)
    );

    btn_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_tenmin (
        .clk   (clk100MHz),
        .rst   (rst),
        .din   (tenminbtn),
        .pulse (tenmin_p)
    );

    always_comb begin
        sec_wrap    = tick_p && (sec_cnt >= 6'(SEC_PER_MIN - 1));
        now_nxt     = now_q;
        pending_nxt = pending;
        if (tenmin_p) begin
            now_nxt     = adv_tenmin(now_q);
            pending_nxt = pending | sec_wrap;
        end else if (min_p) begin
            now_nxt     = adv_min(now_q);
            pending_nxt = pending | sec_wrap;
        end else if (sec_wrap || pending) begin
            now_nxt     = adv_min(now_q);
            // both at once can only happen with a tiny SEC_PER_MIN; keep one in reserve
            pending_nxt = sec_wrap & pending;
        end
    end

    always_ff @(posedge clk100MHz) begin
        if (!rst) begin
            sec_cnt <= '0;
            pending <= 1'b0;
            now_q   <= '0;
        end else begin
            if (tick_p) begin
                sec_cnt <= sec_wrap ? '0 : sec_cnt + 6'd1;
            end
            pending <= pending_nxt;
            now_q   <= now_nxt;
        end
    end

    assign tenhrout  = now_q.tenhr;
    assign onehrout  = now_q.onehr;
    assign tenminout = now_q.tenmin;
    assign oneminout = now_q.onemin;

endmodule

// File: tb/tb_digital_clock.sv
// Bench for digital_clock: integer time model feeding a scoreboard queue, a vector table,
// and hand-written sequences for latency, priority, held buttons and mid-count reset.
module tb_digital_clock;

    logic       clk100MHz = 1'b0;
    logic       rst       = 1'b0;
    logic       clk1sec   = 1'b0;
    logic       minbtn    = 1'b0;
    logic       tenminbtn = 1'b0;
    logic [3:0] tenhrout;
    logic [3:0] onehrout;
    logic [3:0] tenminout;
    logic [3:0] oneminout;

    always #5 clk100MHz = ~clk100MHz;

    digital_clock dut (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .clk1sec   (clk1sec),
        .minbtn    (minbtn),
        .tenminbtn (tenminbtn),
        .tenhrout  (tenhrout),
        .onehrout  (onehrout),
        .tenminout (tenminout),
        .oneminout (oneminout)
    );

    typedef enum int {OP_TICK, OP_MIN, OP_TEN} op_e;
    typedef struct {op_e op; int count; int hh; int mm;} vec_t;
    typedef struct {int hh; int mm;} exp_t;

    int   checks = 0;
    int   errors = 0;
    int   m_hh, m_mm, m_sec;
    exp_t sbq[$];
    vec_t vecs[11];
    int   changes[$];

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_time(input string nm, input int hh, input int mm);
        logic [15:0] act, exp;
        act = {tenhrout, onehrout, tenminout, oneminout};
        exp = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_min();
        m_mm++;
        if (m_mm == 60) begin
            m_mm = 0;
            m_hh = (m_hh + 1) % 24;
        end
    endtask

    task automatic model_apply(input op_e op);
        case (op)
            OP_TICK: begin
                m_sec++;
                if (m_sec == 60) begin
                    m_sec = 0;
                    model_min();
                end
            end
            OP_MIN: model_min();
            default: begin
                m_mm = m_mm + 10;
                if (m_mm >= 60) begin
                    m_mm = m_mm - 60;
                    m_hh = (m_hh + 1) % 24;
                end
            end
        endcase
    endtask

    task automatic drive(input op_e op, input logic v);
        case (op)
            OP_TICK: clk1sec   = v;
            OP_MIN:  minbtn    = v;
            default: tenminbtn = v;
        endcase
    endtask

    // One press: push the model's expectation, let the pulse settle, then pop and compare.
    task automatic press(input op_e op, input string nm);
        exp_t e;
        drive(op, 1'b1);
        model_apply(op);
        sbq.push_back('{m_hh, m_mm});
        repeat (2) @(negedge clk100MHz);
        drive(op, 1'b0);
        repeat (3) @(negedge clk100MHz);
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty got 0 entries expected 1", nm);
        end else begin
            e = sbq.pop_front();
            check_time(nm, e.hh, e.mm);
        end
    endtask

    task automatic do_reset();
        @(negedge clk100MHz);
        rst = 1'b0;
        repeat (3) @(negedge clk100MHz);
        rst  = 1'b1;
        m_hh = 0;
        m_mm = 0;
        m_sec = 0;
        sbq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{OP_TEN, 6, 1, 0};
        vecs[1]  = '{OP_TEN, 132, 23, 0};
        vecs[2]  = '{OP_TEN, 5, 23, 50};
        vecs[3]  = '{OP_MIN, 9, 23, 59};
        vecs[4]  = '{OP_MIN, 1, 0, 0};
        vecs[5]  = '{OP_MIN, 10, 0, 10};
        vecs[6]  = '{OP_TEN, 142, 23, 50};
        vecs[7]  = '{OP_MIN, 3, 23, 53};
        vecs[8]  = '{OP_TEN, 1, 0, 3};
        vecs[9]  = '{OP_MIN, 7, 0, 10};
        vecs[10] = '{OP_TICK, 60, 0, 11};

        do_reset();
        check_time("reset", 0, 0);

        // 59 ticks leave the minute alone; the 60th shows up on the third edge
        for (int i = 0; i < 59; i++) press(OP_TICK, "tick59");
        check_int("onemin_after59", int'(oneminout), 0);
        clk1sec = 1'b1;
        model_apply(OP_TICK);
        @(posedge clk100MHz); #1;
        check_int("t60_edge1", int'(oneminout), 0);
        @(posedge clk100MHz); #1;
        check_int("t60_edge2", int'(oneminout), 0);
        @(posedge clk100MHz); #1;
        check_int("t60_edge3", int'(oneminout), 1);
        @(negedge clk100MHz);
        clk1sec = 1'b0;
        repeat (3) @(negedge clk100MHz);

        do_reset();
        check_time("reset_nonzero", 0, 0);

        begin
            int prev_m;
            prev_m = int'(oneminout);
            for (int i = 1; i <= 133; i++) begin
                press(OP_TICK, "run133");
                if (int'(oneminout) != prev_m) changes.push_back(i);
                prev_m = int'(oneminout);
            end
        end
        check_time("run133_final", 0, 2);
        check_int("run133_nchanges", changes.size(), 2);
        if (changes.size() >= 2) begin
            check_int("first_change_rise", changes[0], 60);
            check_int("change_spacing", changes[1] - changes[0], 60);
        end

        @(negedge clk100MHz);
        minbtn = 1'b1;
        model_min();
        repeat (100) @(negedge clk100MHz);
        minbtn = 1'b0;
        repeat (5) @(negedge clk100MHz);
        check_time("hold100", m_hh, m_mm);
        check_time("hold100_abs", 0, 3);

        do_reset();
        for (int i = 0; i < 11; i++) begin
            for (int n = 0; n < vecs[i].count; n++) press(vecs[i].op, $sformatf("sb_vec%0d", i));
            check_time($sformatf("vec%0d", i), vecs[i].hh, vecs[i].mm);
        end

        // all three events land in one cycle
        do_reset();
        for (int i = 0; i < 59; i++) press(OP_TICK, "simul_pre");
        clk1sec   = 1'b1;
        minbtn    = 1'b1;
        tenminbtn = 1'b1;
        repeat (2) @(posedge clk100MHz);
        @(posedge clk100MHz); #1;
        check_time("simul_ten_first", 0, 10);
        @(posedge clk100MHz); #1;
        check_time("simul_pending", 0, 11);
        @(negedge clk100MHz);
        clk1sec   = 1'b0;
        minbtn    = 1'b0;
        tenminbtn = 1'b0;
        repeat (5) @(negedge clk100MHz);
        check_time("simul_min_lost", 0, 11);
        m_hh = 0;
        m_mm = 11;
        m_sec = 0;
        for (int i = 0; i < 60; i++) press(OP_TICK, "simul_post");
        check_time("simul_next_min", 0, 12);

        do_reset();
        for (int i = 0; i < 30; i++) press(OP_TICK, "mid_pre");
        do_reset();
        check_time("midreset", 0, 0);
        for (int i = 0; i < 59; i++) press(OP_TICK, "mid_post");
        check_time("midreset_59", 0, 0);
        press(OP_TICK, "mid_60");
        check_time("midreset_60", 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
